// File: rtl/dma_fifo_pkg.sv
// rtl/dma_fifo_pkg.sv - shared constants and helpers for the DMA FIFO
package dma_fifo_pkg;

  localparam int DMA_DATA_W     = 32;
  localparam int DMA_FIFO_DEPTH = 16;

  // Bit positions inside the optional err vector
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  // Memory index width for a given depth; a depth of 1 still gets one bit
  function automatic int addr_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM with one write port and one registered read port
module fifo_mem
  import dma_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_W,
  parameter int DEPTH      = DMA_FIFO_DEPTH,
  localparam int ADDR_W    = addr_w_of(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array: written on accepted writes, never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port: updates only on an accepted read, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - synchronous FIFO with lap-bit pointers, count and threshold flags (optional FIFO_ERR_FLAGS_EN)
module sync_fifo_flags
  import dma_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_W,
  parameter int DEPTH      = DMA_FIFO_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int ADDR_W    = addr_w_of(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                  err_clr,
  output logic [1:0]            err,
`endif
  output logic [ADDR_W:0]       count
);

  localparam logic [ADDR_W:0] ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AE_THRESH);

  logic [ADDR_W:0] w_ptr;
  logic [ADDR_W:0] r_ptr;
  logic [ADDR_W:0] count_q;
  logic            wr_ok;
  logic            rd_ok;

  // Flags decode registered state only, so they never glitch within a cycle
  always_comb begin
    empty        = (w_ptr == r_ptr);
    full         = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
                   (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
    almost_full  = (count_q >= AF_LVL);
    almost_empty = (count_q <= AE_LVL);
    count        = count_q;
  end

  // Accepts use pre-edge flags: a read cannot free space for a same-edge write
  always_comb begin
    wr_ok = w_en & ~full;
    rd_ok = r_en & ~empty;
  end

  // Write pointer; the extra MSB is the lap bit distinguishing full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
    end else if (wr_ok) begin
      w_ptr <= w_ptr + ONE;
    end
  end

  // Read pointer, same lap-bit scheme as the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (rd_ok) begin
      r_ptr <= r_ptr + ONE;
    end
  end

  // Occupancy counter; a simultaneous read and write leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (wr_ok && !rd_ok) begin
      count_q <= count_q + ONE;
    end else if (rd_ok && !wr_ok) begin
      count_q <= count_q - ONE;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (w_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (r_ptr[ADDR_W-1:0]),
    .rdata (data_out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic [1:0] err_set;

  // Error events are the rejected requests themselves
  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = w_en & full;
    err_set[ERR_UDF] = r_en & empty;
  end

  // Sticky error bits; a new event in the clearing cycle wins over the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      err <= err_set | (err & {2{~err_clr}});
    end
  end
`endif

  // The counter must always agree with the pointer difference
  assert property (@(posedge clk) disable iff (!rst_n) count_q == (w_ptr - r_ptr));

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags (covers FIFO_ERR_FLAGS_EN when defined)
module tb_sync_fifo_flags;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AF = DP - 2;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_en;
  logic [DW-1:0] data_in;
  logic          r_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          err_clr;
  logic [1:0]    err;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic          rd_issued = 1'b0;
  logic          seen_full;
  int            max_cnt;

  sync_fifo_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr      (err_clr),
    .err          (err),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: one cycle after a read edge the bench expects, pop and compare data_out
  always @(posedge clk) begin
    if (rd_issued) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rdata actual=%h required=<none queued>", data_out);
      end else begin
        chk("rdata", data_out, exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the bench model decides acceptance from pre-edge occupancy
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    bit wr_ok;
    bit rd_ok;
    int n;
    @(negedge clk);
    w_en    = w;
    data_in = d;
    r_en    = r;
    wr_ok   = w && (mq.size() != DP);
    rd_ok   = r && (mq.size() != 0);
    if (rd_ok) exp_q.push_back(mq.pop_front());
    rd_issued = rd_ok;
    if (wr_ok) mq.push_back(d);
    @(posedge clk);
    #2;
    rd_issued = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    n = mq.size();
    if (n > max_cnt) max_cnt = n;
    if (full) seen_full = 1'b1;
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DP));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = '0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);
    chk("reset_data_out", data_out, 32'h0);

    // Fill to full; almost_full must rise exactly at count 14
    for (int i = 0; i < DP; i++) begin
      cycle(1'b1, 32'h1000 + 32'(i), 1'b0);
      if (i == AF - 2) chk("af_before_14", 32'(almost_full), 32'h0);
      if (i == AF - 1) chk("af_at_14", 32'(almost_full), 32'h1);
    end
    chk("full_at_16", 32'(full), 32'h1);
    cycle(1'b1, 32'hDEAD, 1'b0);
    chk("drop_count", 32'(count), 32'd16);

    // Drain in order, then a read on empty must hold the last word
    for (int i = 0; i < DP; i++) cycle(1'b0, '0, 1'b1);
    chk("drained_empty", 32'(empty), 32'h1);
    cycle(1'b0, '0, 1'b1);
    chk("hold_last", data_out, 32'h100F);

    // Wrap-around: pointers travel well past 2*DEPTH
    seen_full = 1'b0;
    max_cnt   = 0;
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h2000 + 32'(lap * 16 + i), 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    end
    chk("wrap_max_count", 32'(max_cnt), 32'd10);
    chk("wrap_never_full", 32'(seen_full), 32'h0);

    // Simultaneous read/write at half full keeps occupancy steady
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h3000 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h3100 + 32'(i), 1'b1);
    chk("rw_count_8", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

    // Simultaneous read/write at full: read taken, write dropped
    for (int i = 0; i < DP; i++) cycle(1'b1, 32'h4000 + 32'(i), 1'b0);
    cycle(1'b1, 32'hBEEF, 1'b1);
    chk("full_rw_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
    chk("full_rw_empty", 32'(empty), 32'h1);

    // Asynchronous reset between edges at count 5
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h5000 + 32'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("pre_reset_count", 32'(count), 32'd5);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_data_out", data_out, 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_almost_empty", 32'(almost_empty), 32'h1);
    chk("arst_full", 32'(full), 32'h0);
    chk("arst_almost_full", 32'(almost_full), 32'h0);
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);
    chk("post_reset_data_out", data_out, 32'h0);

`ifdef FIFO_ERR_FLAGS_EN
    chk("err_reset", 32'(err), 32'h0);
    for (int i = 0; i < DP; i++) cycle(1'b1, 32'h6000 + 32'(i), 1'b0);
    chk("err_none_yet", 32'(err), 32'h0);
    cycle(1'b1, 32'hDEAD, 1'b0);
    chk("err_overflow", 32'(err), 32'h1);
    for (int i = 0; i < DP; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("err_underflow", 32'(err), 32'h3);
    err_clr = 1'b1;
    cycle(1'b0, '0, 1'b1);
    chk("err_set_beats_clr", 32'(err), 32'h2);
    cycle(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO for the AXI4-Lite DMA datapath, buffering read-channel beats before the write channel drains them. Successor to the basic DMA FIFO, with these additions:
- true full detection via wrapped pointers with a lap bit;
- occupancy count output;
- programmable almost-full and almost-empty flags, which give the DMA engine early backpressure;
- asynchronous active-low reset.

Parameters:
- DATA_WIDTH, 32: width of data_in and data_out in bits.
- DEPTH, 16: number of entries; must be a power of 2 and ≥ 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request.
- data_out  out  DATA_WIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asserted asynchronously and released synchronously to clk by the system.
- On reset, all state clears:
  - w_ptr = 0, r_ptr = 0, count = 0, data_out = 0;
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (given the legal AF_THRESH range).
- Memory contents are not reset.
- Pointers are ADDR_W+1 bits, where ADDR_W = $clog2(DEPTH). The low ADDR_W bits index memory; the MSB is the lap bit.
  - empty = (w_ptr == r_ptr).
  - full = (MSBs differ) and (low bits are equal).
  - Pointers wrap naturally modulo 2·DEPTH.
- Write accept: wr_ok = w_en & ~full. On the edge, mem[w_ptr low bits] <= data_in and w_ptr increments.
- Read accept: rd_ok = r_en & ~empty. On the edge, data_out <= mem[r_ptr low bits] and r_ptr increments.
  - Read latency is 1 cycle: data is valid on data_out in the cycle after the accepting edge.
- data_out holds its last value when no read is accepted.
- full, empty and count are evaluated on pre-edge state. Consequences:
  - Write while full is dropped, even if a read is accepted on the same edge.
  - Read while empty is ignored, even if a write is accepted on the same edge.
  - A write to an empty FIFO is readable starting from the next edge.
- Simultaneous wr_ok and rd_ok leave count unchanged; both pointers advance.
- count is a registered counter:
  - +1 on wr_ok only, −1 on rd_ok only, otherwise unchanged;
  - it must always equal w_ptr − r_ptr. This is an assertion target.
- All flags are combinational decodes of registered state, so they are glitch-free relative to clk.
- Reset mid-operation immediately discards all contents and drives outputs to reset values.
- No state machine. Control is the two pointer counters plus the count register.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, add two ports:
  - err_clr (in, 1);
  - err (out, 2): bit0 = overflow, bit1 = underflow.
- Overflow sets on w_en & full. Underflow sets on r_en & empty.
- Both error bits are sticky until err_clr is sampled high or reset; reset value is 0.
- Set beats clear when err_clr and a set event occur in the same cycle.
- When not defined, the ports are absent and no error logic is present.
- Core behaviour is identical in both builds.

Decomposition:
- Package dma_fifo_pkg:
  - localparam-style constants for the defaults: DMA_DATA_W = 32, DMA_FIFO_DEPTH = 16;
  - the ADDR_W derivation helper;
  - error bit index constants ERR_OVF = 0, ERR_UDF = 1.
- One sub-module, fifo_mem: simple dual-port RAM, one write port, one registered read port, parameters DATA_WIDTH and DEPTH.
  - sync_fifo_flags owns pointers, count, flags and errors.

Test Plan:
1. Reset, then idle → empty = 1, almost_empty = 1, full = 0, count = 0, data_out = 0.
2. Write 16 words 0x1000..0x100F (DEPTH = 16) → count = 16, full = 1; almost_full first asserts at count 14. A 17th write of 0xDEAD is dropped and count stays 16.
3. Drain the FIFO full of data → data_out = 0x1000..0x100F in order, each 1 cycle after its read edge. empty = 1 after 16 reads. An extra read leaves data_out = 0x100F.
4. Wrap-around: 3 cycles of fill 10 / drain 10 (pointers pass 2·DEPTH) → data order preserved, count never exceeds 10, full never asserts.
5. At count = 8, assert w_en and r_en together for 20 cycles → count stays 8 and output order is correct. At full, simultaneous w/r → the read is accepted, the write is dropped, count = 15.
6. Assert rst_n low mid-stream at count = 5, between clock edges → outputs go to reset values asynchronously. With FIFO_ERR_FLAGS_EN: write when full → err = 01; read when empty → err = 11; err_clr → err = 00.
